// File: rtl/wire_decl_seq_pkg.sv
// Shared definitions for the wire_decl sequencer/self-checker.
//   VEC_W / NUM_VEC : width and count of the {a,b,c,d} stimulus vectors
//   state_e         : sequencer states
//   golden_out()    : reference AND-OR function used to judge each vector
package wire_decl_seq_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic golden_out(input logic [VEC_W-1:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

endpackage

// File: rtl/wire_decl_seq_if.sv
// Bundle between the sequencer and its environment (control host plus the
// wire_decl gate under test).
//   start                      : host -> sequencer, begin a sweep
//   a, b, c, d                 : sequencer -> gate stimulus
//   out_i, out_n_i             : gate -> sequencer responses
//   busy, done, truth_table,
//   err_count, err             : sequencer -> host results
// slave  : seen by the sequencer
// master : seen by the host/gate side
interface wire_decl_seq_if;

  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        out_i;
  logic        out_n_i;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  err_count;
  logic        err;

  modport slave (
    input  start, out_i, out_n_i,
    output a, b, c, d, busy, done, truth_table, err_count, err
  );

  modport master (
    output start, out_i, out_n_i,
    input  a, b, c, d, busy, done, truth_table, err_count, err
  );

endinterface

// File: rtl/wire_decl_seq_timer.sv
// Dwell counter for the sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force the count back to 0 (sweep start)
//   en_i     : count while the sequencer is driving a vector
//   odd_i    : selects the odd-vector dwell instead of the even one
//   tc_o     : high on the last dwell cycle of the current vector
module wire_decl_seq_timer #(
  parameter int DWELL_EVEN = 2,
  parameter int DWELL_ODD  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic odd_i,
  output logic tc_o
);

  localparam logic [7:0] EVEN_LAST = 8'(DWELL_EVEN - 1);
  localparam logic [7:0] ODD_LAST  = 8'(DWELL_ODD - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] last;

  assign last = odd_i ? ODD_LAST : EVEN_LAST;
  assign tc_o = en_i && (cnt_q == last);

  // Wrapping to 0 on terminal count lets the next vector start cleanly
  // without a separate load cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wire_decl_seq.sv
// Sequencer and self-checker for the wire_decl AND-OR gate pair.
// Steps {a,b,c,d} through all 16 vectors, samples out/out_n on the last
// dwell cycle of each, records a truth table and counts failing vectors.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of wire_decl_seq_if (start, stimulus, gate
//              responses, busy/done and results)
//
// state | meaning
// IDLE  | waiting for start; last results held
// DRIVE | stimulus applied, dwell counting, sample on terminal count
// DONE  | single cycle with done=1, then back to IDLE
module wire_decl_seq
  import wire_decl_seq_pkg::*;
#(
  parameter int DWELL_EVEN = 2,
  parameter int DWELL_ODD  = 1
) (
  input  logic           clk,
  input  logic           rst,
  wire_decl_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_DRIVE = DRIVE;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [4:0]       ERR_MAX  = 5'(NUM_VEC);

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      tt_q, tt_d;
  logic [4:0]       err_cnt_q, err_cnt_d;
  logic             err_q, err_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;
  logic vec_fail;

  assign tmr_clr = (state_q == ST_IDLE) && bus.start;
  assign tmr_en  = (state_q == ST_DRIVE);

  wire_decl_seq_timer #(
    .DWELL_EVEN(DWELL_EVEN),
    .DWELL_ODD (DWELL_ODD)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .odd_i(vec_q[0]),
    .tc_o (tmr_tc)
  );

  // A vector fails on a wrong out or on out_n not being its complement.
  assign vec_fail = (bus.out_i != golden_out(vec_q)) ||
                    (bus.out_n_i != ~bus.out_i);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    tt_d      = tt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          vec_d     = '0;
          tt_d      = '0;
          err_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (tmr_tc) begin
          tt_d[vec_q] = bus.out_i;
          if (vec_fail && (err_cnt_q < ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 5'd1;
          end
          if (vec_q == LAST_VEC) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    err_d = (err_cnt_d != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tt_q      <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tt_q      <= tt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.a           = vec_q[3];
  assign bus.b           = vec_q[2];
  assign bus.c           = vec_q[1];
  assign bus.d           = vec_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.err         = err_q;

endmodule

// File: doc/wire_decl_seq.md
Name: wire_decl_seq

Overview:
Sequencer and self-checker for the wire_decl AND-OR gate pair, where out = (a&b)|(c&d) and out_n = ~out.
- On a start pulse it steps {a,b,c,d} through all 16 input vectors.
- Each vector is held for a programmable dwell: one dwell length for even indices, another for odd.
- On the last dwell cycle of each vector it samples out/out_n, builds a 16-bit truth table and counts mismatches against a golden model.
- It sits between a test/control host and one wire_decl instance, replacing the open-loop stimulus loop.

Parameters:
DWELL_EVEN, 2, cycles each even-indexed vector is held; legal 1..255.
DWELL_ODD, 1, cycles each odd-indexed vector is held; legal 1..255.

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin sweep; sampled only in IDLE.
a  output  1  wire_decl input a = vec[3].
b  output  1  wire_decl input b = vec[2].
c  output  1  wire_decl input c = vec[1].
d  output  1  wire_decl input d = vec[0].
out_i  input  1  wire_decl out.
out_n_i  input  1  wire_decl out_n.
busy  output  1  high while in DRIVE.
done  output  1  one-cycle pulse when the sweep completes.
truth_table  output  16  bit i = sampled out_i for vector i.
err_count  output  5  number of failing vectors, 0..16.
err  output  1  (err_count != 0).

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge):
  - state=IDLE, vec=0, dwell counter=0.
  - busy=0, done=0, truth_table=0, err_count=0.
  - Reset has priority over every other event, including mid-sweep: the sweep is abandoned and results are cleared.
- States: IDLE, DRIVE, DONE.
- IDLE, start=1 at an edge:
  - vec=0, cnt=0, truth_table=0, err_count=0, busy=1, next state DRIVE.
  - start=0: remain in IDLE; previous results and vec are held.
- DRIVE:
  - dwell = DWELL_EVEN if vec[0]==0, else DWELL_ODD.
  - At each edge with cnt < dwell-1: cnt++.
  - At the edge with cnt == dwell-1 (sample edge):
    - truth_table[vec] <= out_i.
    - Vector fails if out_i != expected or out_n_i != ~out_i, where expected = (a&b)|(c&d) computed from the current vec. On a fail, err_count++ (saturates at 16; cannot exceed it).
    - cnt <= 0.
    - If vec==15: next state DONE, busy<=0, done<=1, vec holds at 15.
    - Otherwise vec++.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next edge: done<=0, state IDLE.
  - A start seen in DONE is ignored.
- start asserted while busy or done is ignored; it is not queued.
- Timing from the start-sampling edge k:
  - Last sample at edge k + 8*(DWELL_EVEN+DWELL_ODD).
  - done is high in the following cycle.
  - Defaults give k+24.
- Dwell of 1 means one cycle per vector, with the sample taken at the first edge after vec changes.
- Results stay stable from DONE until the next start or reset.
- Counter widths: cnt is 8 bits; vec is 4 bits with no wrap (the sweep terminates at 15).

Decomposition:
- Package wire_decl_seq_pkg contains:
  - state enum {IDLE, DRIVE, DONE}.
  - VEC_W=4, NUM_VEC=16.
  - function golden_out(vec) returning (v[3]&v[2])|(v[1]&v[0]).
- One natural sub-module, wire_decl_seq_timer: 8-bit dwell counter with a load/parity-select input and a terminal-count output.
- The FSM, capture logic and error logic stay in the top module.

Test Plan:
- Defaults with a correct wire_decl; rst, then start pulse at edge k -> busy from k to k+24, done high one cycle after edge k+24, truth_table=16'hF888, err_count=0, err=0.
- out_n tied to out (faulty) -> every vector fails: err_count=16, err=1, truth_table=16'hF888.
- out stuck 0, out_n=1 -> truth_table=16'h0000, err_count=7 (vectors 3,7,11,12,13,14,15).
- start re-pulsed at vec=6 mid-sweep, and again during the DONE cycle -> both ignored; single sweep, done pulses once at k+24.
- rst asserted at vec=5 -> next cycle IDLE, busy=0, outputs all 0; a new start runs a full sweep with correct results.
- DWELL_EVEN=1, DWELL_ODD=1 -> a,b,c,d change every cycle, done one cycle after edge k+16; DWELL_EVEN=3, DWELL_ODD=5 -> done one cycle after edge k+64.
